// File: rtl/pipelined_control.sv
// RV32 mini decoder feeding the ID/EX register: valid/ready on both sides,
// flush, one-bubble load-use stall and a post-MUL issue hold.
module pipelined_control #(
   parameter int MUL_LATENCY = 4,
   parameter bit ENABLE_MUL  = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr,
   input  logic        ex_readmem,
   input  logic [4:0]  ex_rd,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        selimregb,
   output logic        selregdest,
   output logic        selwsource,
   output logic        writereg,
   output logic        writeov,
   output logic        unsig,
   output logic        readmem,
   output logic        writemem,
   output logic [2:0]  aluop,
   output logic [1:0]  selbrjumpz,
   output logic [2:0]  compop,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [4:0]  rd,
   output logic        illegal,
   output logic        busy
);

   typedef struct packed {
      logic       selimregb;
      logic       selregdest;
      logic       selwsource;
      logic       writereg;
      logic       writeov;
      logic       unsig;
      logic       readmem;
      logic       writemem;
      logic [2:0] aluop;
      logic [1:0] selbrjumpz;
      logic [2:0] compop;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       illegal;
   } ctrl_t;

   typedef enum logic [0:0] {RUN, MUL_HOLD} state_t;

   ctrl_t      dec, bnd;
   state_t     state;
   logic [3:0] cnt;
   logic       legal, use1, use2, hazard, accept, handoff;

   wire [6:0] opc = instr[6:0];
   wire [2:0] f3  = instr[14:12];
   wire [6:0] f7  = instr[31:25];

   always_comb begin
      dec   = '0;
      legal = 1'b1;
      use1  = 1'b1;
      use2  = 1'b0;
      case (opc)
         7'b0110011: begin
            use2           = 1'b1;
            dec.selregdest = 1'b1;
            dec.writereg   = 1'b1;
            if (f3 == 3'b000 && f7 == 7'b0000000)                    dec.aluop = 3'b010;
            else if (f3 == 3'b000 && f7 == 7'b0100000)               dec.aluop = 3'b110;
            else if (f3 == 3'b000 && f7 == 7'b0000001 && ENABLE_MUL) dec.aluop = 3'b011;
            else                                                     legal = 1'b0;
         end
         7'b0010011: begin
            dec.selimregb = 1'b1;
            dec.writereg  = 1'b1;
            dec.aluop     = 3'b010;
            legal         = (f3 == 3'b000);
         end
         7'b0000011: begin
            dec.selimregb  = 1'b1;
            dec.selwsource = 1'b1;
            dec.writereg   = 1'b1;
            dec.readmem    = 1'b1;
            dec.aluop      = 3'b010;
            legal          = (f3 == 3'b010);
         end
         7'b0100011: begin
            use2          = 1'b1;
            dec.selimregb = 1'b1;
            dec.writemem  = 1'b1;
            dec.aluop     = 3'b010;
            legal         = (f3 == 3'b010);
         end
         7'b1100011: begin
            use2           = 1'b1;
            dec.selbrjumpz = 2'b10;
            dec.aluop      = 3'b110;
            dec.compop     = (f3 == 3'b001) ? 3'b101 : 3'b000;
            legal          = (f3 == 3'b000) || (f3 == 3'b001);
         end
         default: legal = 1'b0;
      endcase
      if (!legal) begin
         dec         = '0;
         dec.illegal = 1'b1;
         use1        = 1'b0;
         use2        = 1'b0;
      end
      // register fields only carry addresses the instruction actually uses
      dec.rs1 = use1 ? instr[19:15] : 5'd0;
      dec.rs2 = use2 ? instr[24:20] : 5'd0;
      dec.rd  = dec.writereg ? instr[11:7] : 5'd0;
   end

   assign hazard = ex_readmem && (ex_rd != 5'd0) &&
                   ((use1 && ex_rd == instr[19:15]) || (use2 && ex_rd == instr[24:20]));
   assign in_ready = (state == RUN) && !hazard && (!out_valid || out_ready) && !flush;
   assign accept   = in_valid && in_ready;
   assign handoff  = out_valid && out_ready && (bnd.aluop == 3'b011);

   always_ff @(posedge clock) begin
      if (reset || flush) begin
         out_valid <= 1'b0;
         bnd       <= '0;
         state     <= RUN;
         cnt       <= '0;
      end else begin
         if (accept) begin
            bnd       <= dec;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         case (state)
            RUN: if (handoff && MUL_LATENCY > 1) begin
               state <= MUL_HOLD;
               cnt   <= 4'(MUL_LATENCY - 1);
            end
            MUL_HOLD: if (cnt == 4'd1) begin
               state <= RUN;
               cnt   <= '0;
            end else begin
               cnt <= cnt - 4'd1;
            end
            default: state <= RUN;
         endcase
      end
   end

   assign busy       = (state == MUL_HOLD);
   assign selimregb  = bnd.selimregb;
   assign selregdest = bnd.selregdest;
   assign selwsource = bnd.selwsource;
   assign writereg   = bnd.writereg;
   assign writeov    = bnd.writeov;
   assign unsig      = bnd.unsig;
   assign readmem    = bnd.readmem;
   assign writemem   = bnd.writemem;
   assign aluop      = bnd.aluop;
   assign selbrjumpz = bnd.selbrjumpz;
   assign compop     = bnd.compop;
   assign rs1        = bnd.rs1;
   assign rs2        = bnd.rs2;
   assign rd         = bnd.rd;
   assign illegal    = bnd.illegal;

endmodule
